// File: rtl/fifo_spi_pkg.sv
// Shared definitions for the fifo_spi write-port scheduler.
//   state_e    : scheduler FSM encoding (2'b11 is unused and recovers to S_IDLE)
//   DATA_W_DEF : default fifo_spi word width
//   GAP_W_DEF  : default width of the gap_cycles field
package fifo_spi_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_GAP   = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 32;
  localparam int GAP_W_DEF  = 32;

endpackage

// File: rtl/fifo_spi_sched_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req  in  N_REQ  request vector
//   last in  ID_W   index granted last time; the scan starts at last+1
//   any  out 1      at least one request is set
//   win  out ID_W   first set request found scanning last+1, last+2, ... (wrapping)
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last,
  output logic             any,
  output logic [ID_W-1:0]  win
);

  int               idx;
  logic [ID_W-1:0]  idx_l;

  always_comb begin
    any   = 1'b0;
    win   = '0;
    idx   = 0;
    idx_l = '0;
    // Walk from the farthest candidate (last itself) back to the nearest
    // (last+1); later hits overwrite earlier ones, so the nearest set request wins.
    for (int k = N_REQ; k >= 1; k--) begin
      idx   = (int'(last) + k) % N_REQ;
      idx_l = ID_W'(idx);
      if (req[idx_l]) begin
        any = 1'b1;
        win = idx_l;
      end
    end
  end

endmodule

// File: rtl/fifo_spi_sched.sv
// fifo_spi_sched: round-robin scheduler sharing the fifo_spi write port
// (we/din) between N_REQ producers, with a programmable minimum gap between
// writes and an MCU hold-off (spi_block).
//   clk        in   system clock, rising edge
//   nrst       in   asynchronous reset, active-low
//   enable     in   1 = new grants allowed
//   gap_cycles in   idle spacing between writes, sampled when leaving WRITE
//   spi_block  in   MCU busy, asynchronous (synchronized here)
//   req        in   per-requester request, held until ack
//   data       in   requester i word at data[i*DATA_W +: DATA_W]
//   ack        out  one-cycle pulse per written word
//   we         out  fifo_spi write strobe
//   din        out  fifo_spi write data, held after the strobe
//   grant_id   out  index of the last granted requester
//   busy       out  FSM not in IDLE
//   words_sent out  write count, wraps
module fifo_spi_sched
  import fifo_spi_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int DATA_W      = DATA_W_DEF,
  parameter  int GAP_W       = GAP_W_DEF,
  parameter  int SYNC_STAGES = 2,
  localparam int ID_W        = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    enable,
  input  logic [GAP_W-1:0]        gap_cycles,
  input  logic                    spi_block,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data,
  output logic [N_REQ-1:0]        ack,
  output logic                    we,
  output logic [DATA_W-1:0]       din,
  output logic [ID_W-1:0]         grant_id,
  output logic                    busy,
  output logic [31:0]             words_sent
);

  state_e                 state_q, state_d;
  logic [GAP_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [ID_W-1:0]        last_grant_q, last_grant_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic [N_REQ-1:0]       ack_q, ack_d;
  logic                   we_q, we_d;
  logic                   busy_q, busy_d;
  logic [DATA_W-1:0]      din_q, din_d;
  logic [31:0]            words_sent_q, words_sent_d;

  logic                   blk_s;
  logic                   any;
  logic [ID_W-1:0]        win;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req  (req),
    .last (last_grant_q),
    .any  (any),
    .win  (win)
  );

  assign blk_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], spi_block};
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    ack_d        = '0;
    we_d         = 1'b0;
    din_d        = din_q;
    words_sent_d = words_sent_q;

    case (state_q)
      S_IDLE: begin
        if (enable && any && !blk_s) begin
          din_d        = data[int'(win)*DATA_W +: DATA_W];
          grant_id_d   = win;
          last_grant_d = win;
          ack_d[win]   = 1'b1;
          we_d         = 1'b1;
          state_d      = S_WRITE;
        end
      end
      S_WRITE: begin
        // The word is committed once WRITE has been visible for its cycle.
        cnt_d        = gap_cycles;
        words_sent_d = words_sent_q + 32'd1;
        state_d      = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sync_q       <= '0;
      last_grant_q <= ID_W'(N_REQ - 1);
      grant_id_q   <= '0;
      ack_q        <= '0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      din_q        <= '0;
      words_sent_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sync_q       <= sync_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      ack_q        <= ack_d;
      we_q         <= we_d;
      busy_q       <= busy_d;
      din_q        <= din_d;
      words_sent_q <= words_sent_d;
    end
  end

  assign ack        = ack_q;
  assign we         = we_q;
  assign din        = din_q;
  assign grant_id   = grant_id_q;
  assign busy       = busy_q;
  assign words_sent = words_sent_q;

endmodule
